glyph_map_writer: RTL and testbench

Command-driven writer for the background glyph mapping: accepts rectangle-fill commands over a valid/ready handshake and emits one glyph-mapping write per clock on the `write_glyph`/`addr`/`glyph_id` port of the background controller. It sits between game/CPU logic and the background controller. Tiles are written row-major, clipped to the 20x15 map, with an optional checkerboard rotation pattern.

---
 rtl/glyph_map_writer.sv | 103 ++++++++++
 tb/tb_glyph_map_writer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/glyph_map_writer.sv
// glyph_map_writer: clipped rectangle fill of the background glyph map, one write per clock.
module glyph_map_writer #(
    parameter int MAP_SIZE_X = 20,
    parameter int MAP_SIZE_Y = 15,
    parameter int ID_SIZE    = 6,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_x0,
    input  logic [3:0]            cmd_y0,
    input  logic [4:0]            cmd_w,
    input  logic [3:0]            cmd_h,
    input  logic [ID_SIZE-1:0]    cmd_glyph,
    input  logic                  cmd_mode,
    output logic                  write_glyph,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ID_SIZE-1:0]    glyph_id,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [4:0] x, x0, x_end, x_end_c;
    logic [3:0] y, y_end, y_end_c;
    logic [5:0] x_sum;
    logic [4:0] y_sum;
    logic [ID_SIZE-1:0] glyph;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic mode, fin, empty, last, odd;
    always_comb begin
        x_sum   = {1'b0, cmd_x0} + {1'b0, cmd_w};
        y_sum   = {1'b0, cmd_y0} + {1'b0, cmd_h};
        x_end_c = x_sum > 6'(MAP_SIZE_X) ? 5'(MAP_SIZE_X - 1) : 5'(x_sum - 6'd1);
        y_end_c = y_sum > 5'(MAP_SIZE_Y) ? 4'(MAP_SIZE_Y - 1) : 4'(y_sum - 5'd1);
        empty   = cmd_w == 5'd0 || cmd_h == 4'd0 || cmd_x0 >= 5'(MAP_SIZE_X) || cmd_y0 >= 4'(MAP_SIZE_Y);
        last    = x == x_end && y == y_end;
        odd     = mode & (x[0] ^ y[0]);
    end
    assign cmd_ready = state == IDLE;
    // fin marks that the last tile has been issued; the following RUN cycle raises done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            write_glyph <= 1'b0;
            addr        <= '0;
            glyph_id    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            x           <= '0;
            y           <= '0;
            x0          <= '0;
            x_end       <= '0;
            y_end       <= '0;
            glyph       <= '0;
            mode        <= 1'b0;
            fin         <= 1'b0;
            cur_addr    <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    fin      <= empty;
                    x        <= cmd_x0;
                    y        <= cmd_y0;
                    x0       <= cmd_x0;
                    x_end    <= x_end_c;
                    y_end    <= y_end_c;
                    glyph    <= cmd_glyph;
                    mode     <= cmd_mode;
                    cur_addr <= ADDR_WIDTH'(cmd_y0) * ADDR_WIDTH'(MAP_SIZE_X) + ADDR_WIDTH'(cmd_x0);
                end
                RUN: if (fin) begin
                    write_glyph <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end else begin
                    write_glyph <= 1'b1;
                    addr        <= cur_addr;
                    glyph_id    <= {glyph[ID_SIZE-1:2], glyph[1:0] ^ {odd, 1'b0}};
                    fin         <= last;
                    if (x < x_end) begin
                        x        <= x + 5'd1;
                        cur_addr <= cur_addr + 1'b1;
                    end else if (y != y_end) begin
                        x        <= x0;
                        y        <= y + 4'd1;
                        cur_addr <= cur_addr + ADDR_WIDTH'(MAP_SIZE_X) - ADDR_WIDTH'(x_end - x0);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_glyph_map_writer.sv
// tb_glyph_map_writer: table vectors, random commands against a loop-based map model, reset abort.
module tb_glyph_map_writer;
    logic clk = 1'b0;
    logic rst_n, cmd_valid, cmd_ready, cmd_mode, write_glyph, busy, done;
    logic [4:0] cmd_x0, cmd_w;
    logic [3:0] cmd_y0, cmd_h;
    logic [5:0] cmd_glyph, glyph_id;
    logic [8:0] addr;
    int checks = 0, errors = 0;

    glyph_map_writer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_glyph(cmd_glyph), .cmd_mode(cmd_mode), .write_glyph(write_glyph),
        .addr(addr), .glyph_id(glyph_id), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] x0;
        logic [3:0] y0;
        logic [4:0] w;
        logic [3:0] h;
        logic [5:0] g;
        logic       m;
        int         cnt;
        int         fa;
        int         la;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic scramble();
        cmd_x0    = 5'($urandom);
        cmd_y0    = 4'($urandom);
        cmd_w     = 5'($urandom);
        cmd_h     = 4'($urandom);
        cmd_glyph = 6'($urandom);
        cmd_mode  = 1'($urandom);
    endtask

    // called at posedge+1 with the writer idle; returns at posedge+1 with it idle again
    task automatic run_cmd(input logic [4:0] x0, input logic [3:0] y0, input logic [4:0] w,
                           input logic [3:0] h, input logic [5:0] g, input logic m, input bit hold,
                           output int cnt, output int fa, output int la);
        int ea[$];
        int ei[$];
        for (int yy = int'(y0); yy < int'(y0) + int'(h) && yy < 15; yy++)
            for (int xx = int'(x0); xx < int'(x0) + int'(w) && xx < 20; xx++) begin
                ea.push_back(yy * 20 + xx);
                ei.push_back((m && ((xx + yy) % 2 == 1)) ? int'(g ^ 6'h02) : int'(g));
            end
        check("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_glyph = g; cmd_mode = m;
        @(posedge clk); #1;
        cmd_valid = hold;
        scramble();
        check("accept_write", write_glyph, 0);
        check("accept_busy", busy, 1);
        check("accept_ready", cmd_ready, 0);
        @(posedge clk); #1;
        cnt = 0; fa = 0; la = 0;
        foreach (ea[i]) begin
            check("write", write_glyph, 1);
            check("addr", addr, ea[i]);
            check("glyph_id", glyph_id, ei[i]);
            check("run_ready", cmd_ready, 0);
            check("run_done", done, 0);
            if (write_glyph) begin
                if (cnt == 0) fa = addr;
                la = addr;
                cnt++;
            end
            scramble();
            @(posedge clk); #1;
        end
        check("done_write", write_glyph, 0);
        check("done", done, 1);
        check("done_busy", busy, 1);
        check("done_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_write", write_glyph, 0);
    endtask

    initial begin
        vec_t tv[6];
        int cnt, fa, la;
        tv[0] = '{5'd3,  4'd2,  5'd1,  4'd1,  6'h15, 1'b0, 1,   43,  43};
        tv[1] = '{5'd0,  4'd0,  5'd20, 4'd15, 6'h04, 1'b0, 300, 0,   299};
        tv[2] = '{5'd18, 4'd13, 5'd5,  4'd4,  6'h2a, 1'b0, 4,   278, 299};
        tv[3] = '{5'd5,  4'd5,  5'd0,  4'd3,  6'h11, 1'b0, 0,   0,   0};
        tv[4] = '{5'd25, 4'd0,  5'd3,  4'd3,  6'h11, 1'b1, 0,   0,   0};
        tv[5] = '{5'd0,  4'd0,  5'd2,  4'd2,  6'h01, 1'b1, 4,   0,   21};
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", write_glyph, 0);
        check("rst_addr", addr, 0);
        check("rst_glyph", glyph_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", cmd_ready, 1);
        foreach (tv[i]) begin
            run_cmd(tv[i].x0, tv[i].y0, tv[i].w, tv[i].h, tv[i].g, tv[i].m, i % 2 == 1, cnt, fa, la);
            check("vec_count", cnt, tv[i].cnt);
            check("vec_first", fa, tv[i].fa);
            check("vec_last", la, tv[i].la);
        end
        for (int r = 0; r < 40; r++)
            run_cmd(5'($urandom_range(0, 24)), 4'($urandom), 5'($urandom), 4'($urandom),
                    6'($urandom), 1'($urandom), 1'($urandom), cnt, fa, la);
        // abort a full-map fill after 50 writes while cmd_valid stays high
        cmd_valid = 1'b1;
        cmd_x0 = 5'd0; cmd_y0 = 4'd0; cmd_w = 5'd20; cmd_h = 4'd15; cmd_glyph = 6'h04; cmd_mode = 1'b0;
        @(posedge clk); #1;
        cmd_x0 = 5'd1; cmd_w = 5'd1; cmd_h = 4'd1;
        repeat (50) @(posedge clk);
        #1;
        check("abort_pre_write", write_glyph, 1);
        check("abort_pre_addr", addr, 49);
        check("abort_busy_ready", cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_write", write_glyph, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", addr, 0);
        cmd_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_abort_write", write_glyph, 0);
            check("post_abort_done", done, 0);
            check("post_abort_ready", cmd_ready, 1);
        end
        run_cmd(5'd3, 4'd2, 5'd1, 4'd1, 6'h15, 1'b0, 1'b0, cnt, fa, la);
        check("post_abort_cmd", fa, 43);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
